fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the hazard/stall stage.
- Owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents one instruction per cycle on instr_o.
- Honours the stall from the hazard stage and redirects on a taken branch, discarding wrong-path words still in flight.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: bubble encoding, major opcodes,
// the fetch buffer entry layout and the fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_BUBBLE = 32'b0;

    // Major opcodes, also decoded by the hazard stage
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // Force a byte address onto a word boundary
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of fetch entries.
// Ports: push_i/data_i write, pop_i read (head_o is the current head),
//        flush_i empties the FIFO and wins over push; full_o/empty_o/count_o status.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       data_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o,
    output fetch_entry_t       head_o
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order req/gnt/rvalid
// requests, buffers returned words and presents one instruction per cycle.
// Ports: clk/rst_n; stop_i stall and br_i/br_target_i redirect from downstream;
//        imem_* memory handshake; instr_o/pc_o/instr_valid_o to the hazard stage.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     BITS       = 32,
    parameter logic [BITS-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stop_i,
    input  logic            br_i,
    input  logic [BITS-1:0] br_target_i,
    output logic            imem_req_o,
    output logic [BITS-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic [BITS-1:0] pc_o,
    output logic            instr_valid_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [BITS-1:0] r_fetch_pc;
    logic [BITS-1:0] w_fetch_pc_nxt;
    logic [BITS-1:0] r_resp_pc;
    logic [BITS-1:0] w_resp_pc_nxt;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] w_outstanding_nxt;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] w_discard_nxt;

    logic             w_req;
    logic             w_grant;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [SUM_W-1:0] w_inflight;
    logic [BITS-1:0]  w_br_pc;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (br_i),
        .data_i  (w_push_entry),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count),
        .head_o  (w_head)
    );

    // Requests in flight plus buffered words never exceed the buffer size,
    // so every response has a slot waiting for it
    assign w_inflight = SUM_W'(r_outstanding) + SUM_W'(w_fifo_count);
    assign w_req      = rst_n & (r_state == ST_RUN) & ~br_i
                      & (w_inflight < SUM_W'(FIFO_DEPTH));
    assign w_grant    = w_req & imem_gnt_i;
    assign w_br_pc    = BITS'(align_word(XLEN'(br_target_i)));

    // Outputs are quiet while held in reset and on the redirect cycle
    assign w_valid = rst_n & ~w_fifo_empty & ~br_i;
    assign w_pop   = w_valid & ~stop_i;

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? w_head.instr : NOP_BUBBLE;
    assign pc_o          = w_valid ? BITS'(w_head.pc) : '0;

    // State and fetch bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= BITS'(align_word(XLEN'(RESET_PC)));
            r_resp_pc     <= BITS'(align_word(XLEN'(RESET_PC)));
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    // Next-state: redirect, response steering and PC advance
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_resp_pc_nxt     = r_resp_pc;
        w_outstanding_nxt = r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid_i);
        w_discard_nxt     = r_discard;
        w_push            = 1'b0;
        w_push_entry.instr = imem_rdata_i;
        w_push_entry.pc    = XLEN'(r_resp_pc);

        if (br_i) begin
            // Every request still in flight is wrong-path; one returning now is dropped now
            w_fetch_pc_nxt = w_br_pc;
            w_resp_pc_nxt  = w_br_pc;
            w_discard_nxt  = r_outstanding - CNT_W'(imem_rvalid_i);
            w_state_nxt    = (w_discard_nxt != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (w_grant) w_fetch_pc_nxt = r_fetch_pc + BITS'(4);
            if (imem_rvalid_i) begin
                if (r_discard != '0) begin
                    w_discard_nxt = r_discard - CNT_W'(1);
                end else begin
                    w_push        = 1'b1;
                    w_resp_pc_nxt = r_resp_pc + BITS'(4);
                end
            end
            if (r_state == ST_FLUSH && w_discard_nxt == '0) w_state_nxt = ST_RUN;
        end
    end

    // The issue rule must keep the buffer from overflowing
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_fifo_full && !w_pop && !br_i));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stop_i;
    logic        br_i;
    logic [31:0] br_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;

    always #5 clk = ~clk;

    fetch_unit #(.BITS(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stop_i        (stop_i),
        .br_i          (br_i),
        .br_target_i   (br_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o)
    );

    typedef struct { logic [31:0] addr; int due; } mem_txn_t;
    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mem_txn_t    mem_q[$];
    req_t        infl_q[$];
    ent_t        fifo_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_pc;
    int          cyc;
    int          lat;
    int          gnt_mode;
    int          n_vec;
    int          n_fail;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc;

    // Instruction memory contents: distinct, nonzero, RV-style low bits
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive memory side, compare against the model, advance model at the edge
    task automatic step();
        bit          rv;
        bit          exp_req;
        bit          exp_valid;
        bit          no_stale;
        bit          dut_req;
        logic [31:0] dut_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        req_t        r;
        ent_t        e;
        mem_txn_t    m;

        rv = rst_n && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        imem_gnt_i    = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        #2;

        no_stale = 1'b1;
        foreach (infl_q[i]) if (infl_q[i].stale) no_stale = 1'b0;
        exp_req   = rst_n && !br_i && no_stale && (infl_q.size() + fifo_q.size() < 2);
        exp_valid = rst_n && (fifo_q.size() > 0) && !br_i;
        exp_instr = exp_valid ? fifo_q[0].instr : 32'h0;
        exp_pc    = exp_valid ? fifo_q[0].pc : 32'h0;

        check("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("addr", imem_addr_o, m_pc);
        check("valid", 32'(instr_valid_o), 32'(exp_valid));
        check("instr", instr_o, exp_instr);
        check("pc", pc_o, exp_pc);

        obs_req = imem_req_o; obs_addr = imem_addr_o; obs_valid = instr_valid_o;
        obs_instr = instr_o;  obs_pc = pc_o;
        dut_req = imem_req_o; dut_addr = imem_addr_o;

        @(posedge clk);
        if (!rst_n) begin
            mem_q.delete(); infl_q.delete(); fifo_q.delete();
            m_pc = 32'h0;
        end else begin
            if (rv) void'(mem_q.pop_front());
            if (dut_req && imem_gnt_i) begin
                m.addr = dut_addr; m.due = cyc + lat;
                mem_q.push_back(m);
                req_log.push_back(dut_addr);
            end
            if (br_i) begin
                fifo_q.delete();
                if (rv && infl_q.size() > 0) void'(infl_q.pop_front());
                foreach (infl_q[i]) infl_q[i].stale = 1'b1;
                m_pc = br_target_i & 32'hFFFF_FFFC;
            end else begin
                if (exp_valid && !stop_i) begin
                    pop_log.push_back(fifo_q[0].pc);
                    void'(fifo_q.pop_front());
                end
                if (rv && infl_q.size() > 0) begin
                    r = infl_q.pop_front();
                    if (!r.stale) begin
                        e.instr = mem_word(r.addr); e.pc = r.addr;
                        fifo_q.push_back(e);
                    end
                end
                if (exp_req && imem_gnt_i) begin
                    r.addr = m_pc; r.stale = 1'b0;
                    infl_q.push_back(r);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int l, input int gm);
        lat = l; gnt_mode = gm;
        rst_n = 1'b0; stop_i = 1'b0; br_i = 1'b0; br_target_i = 32'h0;
        step(); step();
        rst_n = 1'b1;
        req_log.delete(); pop_log.delete();
    endtask

    initial begin
        n_vec = 0; n_fail = 0; cyc = 0; m_pc = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

        // Streaming with 1-cycle memory, then a 3-cycle stall
        do_reset(1, 0);
        check("rst_valid", 32'(obs_valid), 32'd0);
        for (int t = 0; t < 22; t++) begin
            stop_i = (t >= 5 && t <= 7);
            step();
            if (t == 0) begin check("A_first_req", 32'(obs_req), 32'd1); check("A_first_addr", obs_addr, 32'h0); end
            if (t == 2) begin check("A_first_pc", obs_pc, 32'h0); check("A_first_instr", obs_instr, 32'h5A5A_0003); end
            if (t == 3) check("A_second_pc", obs_pc, 32'h4);
            if (t == 6 || t == 7) begin check("A_stall_pc", obs_pc, 32'h8); check("A_stall_req", 32'(obs_req), 32'd0); end
        end
        check("A_pops", 32'(pop_log.size() >= 6), 32'd1);
        foreach (pop_log[i]) check("A_pop_seq", pop_log[i], 32'(i * 4));

        // Redirect to 0x103 with two requests outstanding, latency 3
        do_reset(3, 0);
        for (int t = 0; t < 12; t++) begin
            br_i = (t == 2); br_target_i = 32'h0000_0103;
            step();
            if (t == 2) begin check("C_br_instr", obs_instr, 32'h0); check("C_br_req", 32'(obs_req), 32'd0); end
            if (t == 3 || t == 4) check("C_flush_req", 32'(obs_req), 32'd0);
            if (t == 5) begin check("C_tgt_req", 32'(obs_req), 32'd1); check("C_tgt_addr", obs_addr, 32'h100); end
        end
        check("C_req_log", req_log[2], 32'h100);
        check("C_first_pop", pop_log[0], 32'h100);

        // Redirect coinciding with rvalid and stop
        do_reset(1, 0);
        for (int t = 0; t < 12; t++) begin
            br_i = (t == 5); stop_i = (t == 5); br_target_i = 32'h0000_0040;
            step();
            if (t == 5) begin check("D_br_valid", 32'(obs_valid), 32'd0); check("D_br_instr", obs_instr, 32'h0); end
            if (t == 6) begin check("D_req", 32'(obs_req), 32'd1); check("D_addr", obs_addr, 32'h40); end
            if (t == 8) check("D_pc", obs_pc, 32'h40);
        end
        stop_i = 1'b0; br_i = 1'b0;
        check("D_pop1", pop_log[1], 32'h4);
        check("D_pop2", pop_log[2], 32'h40);

        // Second redirect while flushing
        do_reset(3, 0);
        for (int t = 0; t < 14; t++) begin
            br_i = (t == 2 || t == 3);
            br_target_i = (t == 2) ? 32'h0000_0100 : 32'h0000_0200;
            step();
            if (t == 4) check("E_flush_req", 32'(obs_req), 32'd0);
            if (t == 5) begin check("E_req", 32'(obs_req), 32'd1); check("E_addr", obs_addr, 32'h200); end
        end
        br_i = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 32'h100) check("E_no_0x100", req_log[i], 32'hFFFF_FFFF);
        check("E_req_log", req_log[2], 32'h200);
        check("E_first_pop", pop_log[0], 32'h200);

        // Reset mid-stream with a full buffer
        do_reset(1, 0);
        for (int t = 0; t < 12; t++) begin
            stop_i = (t >= 5 && t <= 7);
            rst_n  = (t != 7);
            step();
            if (t == 6) check("F_full_req", 32'(obs_req), 32'd0);
            if (t == 7) begin
                check("F_rst_req", 32'(obs_req), 32'd0); check("F_rst_valid", 32'(obs_valid), 32'd0);
                check("F_rst_instr", obs_instr, 32'h0);  check("F_rst_pc", obs_pc, 32'h0);
            end
            if (t == 8) begin
                check("F_post_valid", 32'(obs_valid), 32'd0);
                check("F_post_req", 32'(obs_req), 32'd1); check("F_post_addr", obs_addr, 32'h0);
            end
        end
        rst_n = 1'b1; stop_i = 1'b0;

        // Mixed traffic: irregular grants, stalls and redirects
        do_reset(2, 1);
        for (int t = 0; t < 300; t++) begin
            stop_i = ($urandom_range(0, 3) == 0);
            br_i   = ($urandom_range(0, 11) == 0);
            br_target_i = $urandom & 32'h0000_0FFF;
            step();
        end
        stop_i = 1'b0; br_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
